// File: rtl/sub_sched.sv
`default_nettype none
// ============================================================================
// Module   : sub_sched
// Purpose  : Shares one SLICE-bit subtract slice between two requesters to
//            compute WIDTH-bit A-B over NBEATS = WIDTH/SLICE beats, LSB slice
//            first, chaining the borrow between beats. A round-robin arbiter
//            picks the requester, the operands are latched at the grant, and
//            the result is published with N/Z/V/C flags and an owner tag.
// Ports    : clk, reset      - clock (rising edge), sync active-high reset
//            req0/a0/b0      - requester 0 request, minuend, subtrahend
//            req1/a1/b1      - requester 1 request, minuend, subtrahend
//            gnt0/gnt1       - one-cycle pulse: operands accepted
//            busy            - operation in progress (RUN or DONE)
//            valid           - one-cycle pulse: new result on out/flags/owner
//            owner           - requester the current result belongs to
//            out             - A-B mod 2^WIDTH
//            neg/zero/of/carry - sign, zero, signed overflow, ARM carry
// Revision : 1.0 - initial release
// ============================================================================
module sub_sched #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             valid,
    output logic             owner,
    output logic [WIDTH-1:0] out,
    output logic             neg,
    output logic             zero,
    output logic             of,
    output logic             carry
);

    localparam int NBEATS = WIDTH / SLICE;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [BEAT_W-1:0]  beat_q,   beat_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   opa_q,    opa_d;
    logic [WIDTH-1:0]   opb_q,    opb_d;
    logic [WIDTH-1:0]   stage_q,  stage_d;   // partial result, hidden until DONE
    logic               tag_q,    tag_d;     // requester of the op in flight
    logic               last_q,   last_d;    // last granted requester (RR)

    logic               gnt0_q,   gnt0_d;
    logic               gnt1_q,   gnt1_d;
    logic               busy_q,   busy_d;
    logic               valid_q,  valid_d;
    logic               owner_q,  owner_d;
    logic [WIDTH-1:0]   out_q,    out_d;
    logic               neg_q,    neg_d;
    logic               zero_q,   zero_d;
    logic               of_q,     of_d;
    logic               carry_q,  carry_d;

    // ------------------------------------------------------------------
    // Shared slice datapath
    // ------------------------------------------------------------------
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE:0]     slice_diff;   // MSB is the slice borrow-out
    logic [WIDTH-1:0]   stage_full;   // staging with the current slice merged
    logic               win1;

    always_comb begin
        slice_a    = opa_q[beat_q*SLICE +: SLICE];
        slice_b    = opb_q[beat_q*SLICE +: SLICE];
        // An (SLICE+1)-bit difference goes negative exactly when a < b + bi,
        // so its top bit is the borrow-out.
        slice_diff = {1'b0, slice_a} - {1'b0, slice_b} - {{SLICE{1'b0}}, borrow_q};
        stage_full = stage_q;
        stage_full[beat_q*SLICE +: SLICE] = slice_diff[SLICE-1:0];
    end

    // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
    assign win1 = req1 & ~(req0 & last_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        borrow_d = borrow_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        stage_d  = stage_q;
        tag_d    = tag_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        owner_d  = owner_q;
        out_d    = out_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        of_d     = of_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    opa_d    = win1 ? a1 : a0;
                    opb_d    = win1 ? b1 : b0;
                    borrow_d = 1'b0;
                    beat_d   = '0;
                    tag_d    = win1;
                    last_d   = win1;
                    gnt0_d   = ~win1;
                    gnt1_d   = win1;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                stage_d  = stage_full;
                borrow_d = slice_diff[SLICE];
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    // Final beat: publish the whole result and flags at once.
                    beat_d  = '0;
                    out_d   = stage_full;
                    neg_d   = stage_full[WIDTH-1];
                    zero_d  = ~|stage_full;
                    carry_d = ~slice_diff[SLICE];
                    of_d    = (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) &
                              (opa_q[WIDTH-1] ^ stage_full[WIDTH-1]);
                    owner_d = tag_q;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            borrow_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            stage_q  <= '0;
            tag_q    <= 1'b0;
            last_q   <= 1'b1;   // requester 0 wins the first tie
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            owner_q  <= 1'b0;
            out_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            of_q     <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            borrow_q <= borrow_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            stage_q  <= stage_d;
            tag_q    <= tag_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            out_q    <= out_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            of_q     <= of_d;
            carry_q  <= carry_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign owner = owner_q;
    assign out   = out_q;
    assign neg   = neg_q;
    assign zero  = zero_q;
    assign of    = of_q;
    assign carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_sched
// Purpose  : Self-checking bench for sub_sched. Directed cases plus random
//            operations compared against a whole-word arithmetic model and a
//            round-robin arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_sched;

    localparam int W  = 64;
    localparam int S  = 16;
    localparam int NB = W / S;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, valid, owner;
    logic [W-1:0] out;
    logic         neg, zero, of, carry;

    int n_cmp = 0;
    int n_bad = 0;
    bit last_gnt;   // model: last granted requester

    always #5 clk = ~clk;

    sub_sched #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid), .owner(owner),
        .out(out), .neg(neg), .zero(zero), .of(of), .carry(carry)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        last_gnt = 1'b1;
    endtask

    // Whole-word reference: plain W-bit and (W+1)-bit signed arithmetic.
    task automatic expect_result(input logic [W-1:0] a, input logic [W-1:0] b, input bit own);
        logic [W-1:0]        d;
        logic signed [W:0]   s;
        d = a - b;
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        check("out",   out, d);
        check("owner", W'(owner), W'(own));
        check("neg",   W'(neg),   W'($signed(d) < 0));
        check("zero",  W'(zero),  W'(d == '0));
        check("carry", W'(carry), W'(a >= b));
        check("of",    W'(of),    W'(s[W] != s[W-1]));
    endtask

    // One full operation from an idle or finishing scheduler.
    task automatic do_op(input bit r0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input bit r1, input logic [W-1:0] x1, input logic [W-1:0] y1);
        bit win;
        bit seen;
        int lat;
        req0 = r0; a0 = x0; b0 = y0;
        req1 = r1; a1 = x1; b1 = y1;
        win  = (r0 && r1) ? ~last_gnt : r1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (gnt0 | gnt1) seen = 1'b1;
        end
        check("gnt_seen", W'(seen), W'(1));
        if (seen) begin
            check("gnt_excl", W'(gnt0 & gnt1), '0);
            check("gnt_who",  W'(gnt1), W'(win));
            check("busy_run", W'(busy), W'(1));
            last_gnt = win;
            if (win) req1 = 1'b0; else req0 = 1'b0;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!valid && lat < 16);
            check("valid_lat", W'(lat), W'(NB));
            if (valid) begin
                expect_result(win ? x1 : x0, win ? y1 : y0, win);
                req0 = 1'b0; req1 = 1'b0;
                tick();
                check("valid_pulse", W'({valid, busy}), '0);
                check("out_hold", out, win ? (x1 - y1) : (x0 - y0));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 3)) << (S * $urandom_range(0, NB - 1));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int n_gnt;
        int last_t;
        bit pend_own;
        bit cont_tie;
        logic [W-1:0] ra0, rb0, ra1, rb1;
        int sel;

        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        // Reset state
        check("rst_out", out, '0);
        check("rst_ctl", W'({gnt0, gnt1, busy, valid, owner}), '0);
        check("rst_flags", W'({neg, zero, of, carry}), '0);

        // Directed arithmetic cases
        do_op(1, 64'd5, 64'd3, 0, '0, '0);
        do_op(0, '0, '0, 1, 64'd0, 64'd1);
        do_op(0, '0, '0, 1, 64'h0001_0000_0000_0000, 64'd1);
        do_op(1, 64'h8000_0000_0000_0000, 64'd1, 0, '0, '0);
        do_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, '0);
        do_op(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, '0, '0);

        // Continuous contention: both requests held from reset
        ra0 = 64'd100; rb0 = 64'd7; ra1 = 64'd3; rb1 = 64'd9;
        reset = 1'b1;
        req0 = 1'b1; a0 = ra0; b0 = rb0;
        req1 = 1'b1; a1 = ra1; b1 = rb1;
        tick();
        reset = 1'b0;
        last_gnt = 1'b1;
        n_gnt = 0; last_t = 0; pend_own = 1'b0; cont_tie = 1'b0;
        for (int t = 0; t < 26; t++) begin
            tick();
            if (gnt0 | gnt1) begin
                cont_tie = ~last_gnt;
                check("rr_who", W'(gnt1), W'(cont_tie));
                check("rr_excl", W'(gnt0 & gnt1), '0);
                if (n_gnt > 0) check("rr_gap", W'(t - last_t), W'(NB + 2));
                last_gnt = cont_tie;
                pend_own = cont_tie;
                last_t = t;
                n_gnt++;
            end
            if (valid) begin
                check("rr_overlap", W'((gnt0 | gnt1) & valid), '0);
                check("rr_owner", W'(owner), W'(pend_own));
                check("rr_out", out, pend_own ? (ra1 - rb1) : (ra0 - rb0));
            end
        end
        check("rr_count", W'(n_gnt >= 4), W'(1));
        do_reset();

        // Reset during beat 2 of an operation
        req0 = 1'b1; a0 = 64'hDEAD_BEEF_0000_1111; b0 = 64'd1;
        tick();
        check("abort_gnt", W'(gnt0), W'(1));
        req0 = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_gnt = 1'b1;
        check("abort_busy", W'(busy), '0);
        check("abort_out", out, '0);
        sel = 0;
        for (int t = 0; t < 8; t++) begin
            if (valid) sel++;
            tick();
        end
        check("abort_novalid", W'(sel), '0);
        check("abort_out2", out, '0);
        do_op(0, '0, '0, 1, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0002);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            ra0 = pick_operand(); rb0 = pick_operand();
            ra1 = pick_operand(); rb1 = pick_operand();
            if ($urandom_range(0, 7) == 0) rb0 = ra0;
            if ($urandom_range(0, 7) == 0) rb1 = ra1;
            do_op(sel[0], ra0, rb0, sel[1], ra1, rb1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sub_sched.md
Name: sub_sched

Overview:
Multi-cycle scheduler that shares one SLICE-bit subtract slice between two requesters to perform WIDTH-bit A−B. It arbitrates round-robin, latches the operands, and sequences the slice LSB-first over WIDTH/SLICE beats, chaining the borrow between beats. It returns the result with ALU flags (N, Z, V, C) and owner tag, and sits between the ALU front end and the shared subtract datapath.

Parameters:
WIDTH  64  operand/result width; must be a multiple of SLICE
SLICE  16  bits subtracted per beat; NBEATS = WIDTH/SLICE

Ports:
clk    in   1      clock, all logic on rising edge
reset  in   1      synchronous, active-high
req0   in   1      requester 0 request
a0     in   WIDTH  requester 0 minuend
b0     in   WIDTH  requester 0 subtrahend
req1   in   1      requester 1 request
a1     in   WIDTH  requester 1 minuend
b1     in   WIDTH  requester 1 subtrahend
gnt0   out  1      one-cycle pulse: requester 0 operands accepted
gnt1   out  1      one-cycle pulse: requester 1 operands accepted
busy   out  1      high in RUN and DONE
valid  out  1      one-cycle pulse: out/flags/owner hold a new result
owner  out  1      requester the current result belongs to
out    out  WIDTH  A−B (mod 2^WIDTH)
neg    out  1      out[WIDTH-1]
zero   out  1      out == 0
of     out  1      signed overflow
carry  out  1      ARM carry: 1 = no borrow (A >= B unsigned)

Behaviour:
- States: IDLE, RUN, DONE. Reset→IDLE. At reset all outputs are 0, beat=0, borrow=0, and the RR pointer is set so req0 wins the first tie.
- IDLE: at an edge E0 with req0|req1:
  - pick the winner (single requester, or on a tie the one not granted last);
  - latch its a/b into A_r/B_r; clear borrow and beat; set owner;
  - go to RUN. gnt<winner> is high during [E0,E1) only.
- Operands are sampled only at E0. Requesters hold req and operands until they see gnt. A req still high after its gnt is a new request.
- RUN: on each edge, slice k = beat:
  - out[k*SLICE +: SLICE] = A_r slice − B_r slice − borrow;
  - borrow ← slice borrow-out; beat ← beat+1.
  - Bit-level borrow: bo = (~a&b) | (~a&bi) | (b&bi).
  - Out slices not yet written keep their previous values. Internal staging is allowed provided the outputs are updated only at the DONE transition.
- After NBEATS beats (edge E_NBEATS):
  - out, neg, zero, of, carry update together;
  - state→DONE; valid is high during [E_NBEATS, E_NBEATS+1).
  - Default: gnt in cycle 0, valid in cycle 4.
- Flags:
  - neg = out[W-1]; zero = ~|out; carry = ~final borrow;
  - of = (A_r[W-1]^B_r[W-1]) & (A_r[W-1]^out[W-1]).
- DONE: unconditionally go to IDLE on the next edge; requests are not accepted in DONE. Throughput is one op per NBEATS+2 cycles; valid pulses never overlap.
- out, flags and owner hold their values until the next valid. gnt0 and gnt1 are never high together.
- Requests arriving in RUN/DONE are ignored until IDLE; no queueing.
- Reset during RUN or DONE: return to IDLE and clear outputs and RR pointer; no valid is produced for the aborted op.

Test Plan:
1. Reset, then req0 with a0=5, b0=3 → gnt0 in cycle 0, valid in cycle 4, out=2, owner=0, neg=0, zero=0, of=0, carry=1.
2. req1 with a1=0, b1=1 → out=0xFFFF_FFFF_FFFF_FFFF, neg=1, carry=0, of=0. Then a1=0x0001_0000_0000_0000, b1=1 → out=0x0000_FFFF_FFFF_FFFF (borrow crosses three slices), carry=1.
3. a0=0x8000_0000_0000_0000, b0=1 → out=0x7FFF_FFFF_FFFF_FFFF, of=1, neg=0, carry=1. Also a0=0x7FFF_FFFF_FFFF_FFFF, b0=0xFFFF_FFFF_FFFF_FFFF → out=0x8000_0000_0000_0000, of=1, carry=0.
4. a0=b0=0x1234_5678_9ABC_DEF0 → out=0, zero=1, carry=1, neg=0, of=0.
5. req0 and req1 held high continuously after reset → grant order 0,1,0,1, one gnt per 6 cycles, owners match, valid never overlaps a gnt of the same op.
6. Assert reset for one cycle during beat 2 of an op → busy=0 next cycle, no valid for that op, out=0; a subsequent req1 is accepted and completes normally.
